// File: rtl/arp_resolver.sv
// arp_resolver: ARP initiator. On a Resolve pulse it latches TargetIP and
// requests the tx path. On each rising edge of TxGrant it sends a 60-byte
// broadcast ARP request. The parser watches rx frames for the matching
// reply and delivers the sender MAC. It retries after TIMEOUT_CYC idle
// cycles and reports Failed after MAX_TRY transmissions.
//
// Ports
//   Clk, Rst             clock, asynchronous active-high reset
//   Resolve, TargetIP    start pulse and the IP to resolve
//   InnerMAC, InnerIP    local addresses
//   SoFIn/EoFIn/ValIn/ErrIn/DataIn  rx ARP payload byte stream
//   TxGrant, MODE        tx arbiter grant (level), byte rate select
//   TxReq/FrameOut/ValOut/SoFOut/EoFOut/DataOut  tx byte stream
//   Busy, Resolved, Failed, ResolvedMAC  status
//   StateDbg             current FSM state (debug)
//
// Tx handshake: a frame starts only on a 0->1 transition of TxGrant while
// TxReq is high. After that it runs to completion regardless of the grant.
// A byte is transferred on every cycle with ValOut high. No backpressure.
module arp_resolver #(
  parameter int TIMEOUT_CYC = 25000000,
  parameter int MAX_TRY     = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Resolve,
  input  logic [31:0] TargetIP,
  input  logic [47:0] InnerMAC,
  input  logic [31:0] InnerIP,
  input  logic        SoFIn,
  input  logic        EoFIn,
  input  logic        ValIn,
  input  logic        ErrIn,
  input  logic [7:0]  DataIn,
  input  logic        TxGrant,
  input  logic        MODE,
  output logic        TxReq,
  output logic        FrameOut,
  output logic        ValOut,
  output logic        SoFOut,
  output logic        EoFOut,
  output logic [7:0]  DataOut,
  output logic        Busy,
  output logic        Resolved,
  output logic        Failed,
  output logic [47:0] ResolvedMAC,
  output logic [2:0]  StateDbg
);
  localparam int TW_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int TW     = (TW_RAW > 24) ? TW_RAW : 24;
  localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_CYC);
  localparam logic [3:0]    MAX_TRY_L  = 4'(MAX_TRY);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_REQ = 3'd1, S_SEND = 3'd2,
    S_WAIT = 3'd3, S_DONE = 3'd4, S_FAIL = 3'd5
  } state_t;

  state_t        state_q;
  logic [31:0]   tgt_ip_q;
  logic [3:0]    try_q;
  logic [TW-1:0] timer_q;
  logic          grant_q, grant_prev_q;
  logic [5:0]    tx_idx_q;
  logic          tx_gap_q, tx_end_q, match_pend_q;
  logic          tx_req_q, frame_q, val_q, sof_q, eof_q;
  logic [7:0]    data_q;
  logic          resolved_q, failed_q;
  logic [47:0]   res_mac_q, shadow_q;
  logic [7:0]    rx_idx_q;
  logic          rx_ok_q;

  // MSB-first byte selects.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [5:0] k);
    case (k)
      6'd0:    return mac[47:40];
      6'd1:    return mac[39:32];
      6'd2:    return mac[31:24];
      6'd3:    return mac[23:16];
      6'd4:    return mac[15:8];
      default: return mac[7:0];
    endcase
  endfunction

  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [7:0] k);
    case (k)
      8'd0:    return ip[31:24];
      8'd1:    return ip[23:16];
      8'd2:    return ip[15:8];
      default: return ip[7:0];
    endcase
  endfunction

  // Fixed reply header: htype 1, ptype 0800, hlen 6, plen 4, opcode 2.
  function automatic logic [7:0] hdr_byte(input logic [7:0] k);
    case (k)
      8'd1:    return 8'h01;
      8'd2:    return 8'h08;
      8'd4:    return 8'h06;
      8'd5:    return 8'h04;
      8'd7:    return 8'h02;
      default: return 8'h00;
    endcase
  endfunction

  // Request byte for the current tx index.
  logic [7:0] tx_byte_d;
  logic [5:0] tx_off_d;
  always_comb begin
    tx_byte_d = 8'h00;
    tx_off_d  = '0;
    if (tx_idx_q < 6'd6) begin
      tx_byte_d = 8'hFF;
    end else if (tx_idx_q < 6'd12) begin
      tx_off_d  = tx_idx_q - 6'd6;
      tx_byte_d = mac_byte(InnerMAC, tx_off_d);
    end else if (tx_idx_q < 6'd22) begin
      case (tx_idx_q)
        6'd12, 6'd16: tx_byte_d = 8'h08;
        6'd13, 6'd18: tx_byte_d = 8'h06;
        6'd15, 6'd21: tx_byte_d = 8'h01;
        6'd19:        tx_byte_d = 8'h04;
        default:      tx_byte_d = 8'h00;
      endcase
    end else if (tx_idx_q < 6'd28) begin
      tx_off_d  = tx_idx_q - 6'd22;
      tx_byte_d = mac_byte(InnerMAC, tx_off_d);
    end else if (tx_idx_q < 6'd32) begin
      tx_off_d  = tx_idx_q - 6'd28;
      tx_byte_d = ip_byte(InnerIP, {2'b00, tx_off_d});
    end else if (tx_idx_q >= 6'd38 && tx_idx_q < 6'd42) begin
      tx_off_d  = tx_idx_q - 6'd38;
      tx_byte_d = ip_byte(tgt_ip_q, {2'b00, tx_off_d});
    end
  end

  // Rx parser: rx_ok accumulates "every checked byte so far matched".
  // SoF restarts the frame, so a frame cut short by a new SoF is dropped.
  logic [7:0] rx_cur_d, rx_idx_d, rx_off_d;
  logic       rx_byte_ok_d, rx_ok_d, rx_match_d;
  always_comb begin
    rx_cur_d     = SoFIn ? 8'd0 : rx_idx_q;
    rx_idx_d     = (rx_cur_d == 8'hFF) ? 8'hFF : rx_cur_d + 8'd1;
    rx_off_d     = '0;
    rx_byte_ok_d = 1'b1;
    if (rx_cur_d < 8'd8) begin
      rx_byte_ok_d = (DataIn == hdr_byte(rx_cur_d));
    end else if (rx_cur_d >= 8'd14 && rx_cur_d <= 8'd17) begin
      rx_off_d     = rx_cur_d - 8'd14;
      rx_byte_ok_d = (DataIn == ip_byte(tgt_ip_q, rx_off_d));
    end else if (rx_cur_d >= 8'd24 && rx_cur_d <= 8'd27) begin
      rx_off_d     = rx_cur_d - 8'd24;
      rx_byte_ok_d = (DataIn == ip_byte(InnerIP, rx_off_d));
    end
    rx_ok_d    = (SoFIn ? 1'b1 : rx_ok_q) & rx_byte_ok_d;
    rx_match_d = ValIn & EoFIn & ~ErrIn & (rx_cur_d >= 8'd27) & rx_ok_d;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      tgt_ip_q     <= '0;
      try_q        <= '0;
      timer_q      <= '0;
      grant_q      <= 1'b0;
      grant_prev_q <= 1'b0;
      tx_idx_q     <= '0;
      tx_gap_q     <= 1'b0;
      tx_end_q     <= 1'b0;
      match_pend_q <= 1'b0;
      tx_req_q     <= 1'b0;
      frame_q      <= 1'b0;
      val_q        <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      data_q       <= '0;
      resolved_q   <= 1'b0;
      failed_q     <= 1'b0;
      res_mac_q    <= '0;
      shadow_q     <= '0;
      rx_idx_q     <= '0;
      rx_ok_q      <= 1'b0;
    end else begin
      grant_q      <= TxGrant;
      grant_prev_q <= grant_q;

      if (ValIn) begin
        rx_idx_q <= rx_idx_d;
        rx_ok_q  <= EoFIn ? 1'b0 : rx_ok_d;
        if (rx_cur_d >= 8'd8 && rx_cur_d <= 8'd13)
          shadow_q <= {shadow_q[39:0], DataIn};
      end

      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (Resolve) begin
            tgt_ip_q     <= TargetIP;
            resolved_q   <= 1'b0;
            failed_q     <= 1'b0;
            try_q        <= '0;
            match_pend_q <= 1'b0;
            tx_req_q     <= 1'b1;
            state_q      <= S_REQ;
          end
        end
        S_REQ: begin
          if (rx_match_d) begin
            resolved_q <= 1'b1;
            res_mac_q  <= shadow_q;
            tx_req_q   <= 1'b0;
            state_q    <= S_DONE;
          end else if (grant_q && !grant_prev_q) begin
            tx_idx_q <= '0;
            tx_gap_q <= 1'b0;
            tx_end_q <= 1'b0;
            state_q  <= S_SEND;
          end
        end
        S_SEND: begin
          // A reply seen mid-frame is recorded now; the frame still completes.
          if (rx_match_d) begin
            resolved_q   <= 1'b1;
            res_mac_q    <= shadow_q;
            match_pend_q <= 1'b1;
          end
          if (tx_end_q) begin
            frame_q  <= 1'b0;
            val_q    <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            data_q   <= '0;
            tx_req_q <= 1'b0;
            try_q    <= try_q + 4'd1;
            timer_q  <= TIMEOUT_LD;
            state_q  <= (match_pend_q || rx_match_d) ? S_DONE : S_WAIT;
          end else if (tx_gap_q) begin
            // MODE=0 gap cycle: DataOut holds the previous byte.
            val_q    <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            tx_gap_q <= 1'b0;
          end else begin
            frame_q  <= 1'b1;
            val_q    <= 1'b1;
            data_q   <= tx_byte_d;
            sof_q    <= (tx_idx_q == 6'd0);
            eof_q    <= (tx_idx_q == 6'd59);
            tx_gap_q <= !MODE && (tx_idx_q != 6'd59);
            tx_end_q <= (tx_idx_q == 6'd59);
            tx_idx_q <= tx_idx_q + 6'd1;
          end
        end
        S_WAIT: begin
          // Match takes priority over timeout expiry.
          if (rx_match_d) begin
            resolved_q <= 1'b1;
            res_mac_q  <= shadow_q;
            state_q    <= S_DONE;
          end else if (timer_q == '0) begin
            if (try_q < MAX_TRY_L) begin
              tx_req_q <= 1'b1;
              state_q  <= S_REQ;
            end else begin
              failed_q <= 1'b1;
              state_q  <= S_FAIL;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign TxReq       = tx_req_q;
  assign FrameOut    = frame_q;
  assign ValOut      = val_q;
  assign SoFOut      = sof_q;
  assign EoFOut      = eof_q;
  assign DataOut     = data_q;
  assign Busy        = (state_q == S_REQ) || (state_q == S_SEND) || (state_q == S_WAIT);
  assign Resolved    = resolved_q;
  assign Failed      = failed_q;
  assign ResolvedMAC = res_mac_q;
  assign StateDbg    = state_q;
endmodule

// File: tb/tb_arp_resolver.sv
// tb_arp_resolver: directed bench for arp_resolver. A table of rx reply
// records drives request/reply rounds; hand-written sequences cover the
// retry/fail path, MODE=0 pacing, a reply arriving mid-frame, Resolve
// while busy, and reset in the middle of a frame.
`timescale 1ns/1ps
module tb_arp_resolver;
  localparam int TO = 100;
  localparam int MT = 3;
  localparam logic [47:0] MY_MAC = 48'h020000000001;
  localparam logic [31:0] MY_IP  = 32'hC0A80001;
  localparam logic [31:0] TGT    = 32'hC0A80002;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_REQ = 3'd1, ST_SEND = 3'd2,
                         ST_WAIT = 3'd3, ST_DONE = 3'd4, ST_FAIL = 3'd5;

  logic        Clk, Rst, Resolve, SoFIn, EoFIn, ValIn, ErrIn, TxGrant, MODE;
  logic [31:0] TargetIP, InnerIP;
  logic [47:0] InnerMAC, ResolvedMAC;
  logic [7:0]  DataIn, DataOut;
  logic        TxReq, FrameOut, ValOut, SoFOut, EoFOut, Busy, Resolved, Failed;
  logic [2:0]  StateDbg;

  arp_resolver #(.TIMEOUT_CYC(TO), .MAX_TRY(MT)) dut (
    .Clk(Clk), .Rst(Rst), .Resolve(Resolve), .TargetIP(TargetIP),
    .InnerMAC(InnerMAC), .InnerIP(InnerIP), .SoFIn(SoFIn), .EoFIn(EoFIn),
    .ValIn(ValIn), .ErrIn(ErrIn), .DataIn(DataIn), .TxGrant(TxGrant),
    .MODE(MODE), .TxReq(TxReq), .FrameOut(FrameOut), .ValOut(ValOut),
    .SoFOut(SoFOut), .EoFOut(EoFOut), .DataOut(DataOut), .Busy(Busy),
    .Resolved(Resolved), .Failed(Failed), .ResolvedMAC(ResolvedMAC),
    .StateDbg(StateDbg)
  );

  // Clock / watchdog
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [7:0] exp_q[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] opcode;
    logic [47:0] smac;
    logic [31:0] sip;
    logic [31:0] tip;
    logic        err;
    int          len;
    logic        exp_res;
  } rx_vec_t;
  rx_vec_t vecs[7];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic zero_check(input string tag);
    check({tag, "_ctrl"}, {TxReq, FrameOut, ValOut, SoFOut, EoFOut, DataOut,
                           Busy, Resolved, Failed, StateDbg}, 64'd0);
    check({tag, "_mac"}, ResolvedMAC, 64'd0);
  endtask

  // Expected request byte, built straight from the frame layout.
  function automatic logic [7:0] req_byte(input int i, input logic [31:0] tip);
    logic [47:0] m;
    logic [31:0] p;
    if (i < 6) return 8'hFF;
    if (i < 12 || (i >= 22 && i < 28)) begin
      m = MY_MAC >> (8 * (((i < 12) ? 11 : 27) - i));
      return m[7:0];
    end
    case (i)
      12, 16: return 8'h08;
      13, 18: return 8'h06;
      15, 21: return 8'h01;
      19:     return 8'h04;
      default: ;
    endcase
    if (i >= 28 && i < 32) begin p = MY_IP >> (8 * (31 - i)); return p[7:0]; end
    if (i >= 38 && i < 42) begin p = tip >> (8 * (41 - i)); return p[7:0]; end
    return 8'h00;
  endfunction

  task automatic push_req(input logic [31:0] tip);
    exp_q.delete();
    for (int i = 0; i < 60; i++) exp_q.push_back(req_byte(i, tip));
  endtask

  function automatic logic [7:0] rx_byte(input rx_vec_t v, input int i);
    logic [47:0] m;
    logic [31:0] p;
    case (i)
      1: return 8'h01;
      2: return 8'h08;
      4: return 8'h06;
      5: return 8'h04;
      6: return v.opcode[15:8];
      7: return v.opcode[7:0];
      default: ;
    endcase
    if (i >= 8 && i <= 13)  begin m = v.smac >> (8 * (13 - i)); return m[7:0]; end
    if (i >= 14 && i <= 17) begin p = v.sip >> (8 * (17 - i)); return p[7:0]; end
    if (i >= 18 && i <= 23) begin m = MY_MAC >> (8 * (23 - i)); return m[7:0]; end
    if (i >= 24 && i <= 27) begin p = v.tip >> (8 * (27 - i)); return p[7:0]; end
    return 8'h00;
  endfunction

  // Driver tasks
  task automatic do_reset();
    Rst = 1'b1; Resolve = 1'b0; TxGrant = 1'b0;
    SoFIn = 1'b0; EoFIn = 1'b0; ValIn = 1'b0; ErrIn = 1'b0; DataIn = 8'h00;
    tick(); tick();
    Rst = 1'b0;
    tick();
  endtask

  task automatic do_resolve(input logic [31:0] ip);
    Resolve = 1'b1; TargetIP = ip;
    tick();
    Resolve = 1'b0;
  endtask

  task automatic send_reply(input rx_vec_t v, input int nbytes, input bit with_eof);
    for (int i = 0; i < nbytes; i++) begin
      ValIn  = 1'b1;
      SoFIn  = (i == 0);
      EoFIn  = with_eof && (i == nbytes - 1);
      ErrIn  = v.err && EoFIn;
      DataIn = rx_byte(v, i);
      tick();
    end
    ValIn = 1'b0; SoFIn = 1'b0; EoFIn = 1'b0; ErrIn = 1'b0; DataIn = 8'h00;
  endtask

  // Raises the grant; first byte must appear two clocks after it is sampled.
  task automatic grant_and_sof();
    TxGrant = 1'b1;
    tick();
    check("sof_lead1", SoFOut, 1'b0);
    tick();
    check("sof_lead2", SoFOut, 1'b0);
    tick();
  endtask

  // Scoreboard for one tx frame: entered on the byte-0 cycle, leaves on the
  // cycle after EoFOut.
  task automatic capture_frame(input bit mode, input int drop_at);
    logic [7:0] e;
    for (int i = 0; i < 60; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      check($sformatf("tx_byte%0d", i), {FrameOut, ValOut, SoFOut, EoFOut, DataOut},
            {1'b1, 1'b1, (i == 0), (i == 59), e});
      if (i == drop_at) TxGrant = 1'b0;
      tick();
      if (!mode && i != 59) begin
        check($sformatf("tx_gap%0d", i), {FrameOut, ValOut, SoFOut, EoFOut, DataOut},
              {4'b1000, e});
        tick();
      end
    end
    check("tx_after_eof", {FrameOut, ValOut, TxReq}, 3'b000);
  endtask

  int n, cnt;
  rx_vec_t good2;

  initial begin
    Rst = 1'b1; Resolve = 1'b0; TargetIP = '0; TxGrant = 1'b0; MODE = 1'b1;
    SoFIn = 1'b0; EoFIn = 1'b0; ValIn = 1'b0; ErrIn = 1'b0; DataIn = 8'h00;
    InnerMAC = MY_MAC; InnerIP = MY_IP;

    vecs[0] = '{16'h0002, 48'h0A0B0C0D0E0F, TGT,          MY_IP,        1'b0, 28, 1'b1};
    vecs[1] = '{16'h0002, 48'h0A0B0C0D0E0F, TGT,          MY_IP,        1'b1, 28, 1'b0};
    vecs[2] = '{16'h0002, 48'h0A0B0C0D0E0F, 32'hC0A80003, MY_IP,        1'b0, 28, 1'b0};
    vecs[3] = '{16'h0001, 48'h0A0B0C0D0E0F, TGT,          MY_IP,        1'b0, 28, 1'b0};
    vecs[4] = '{16'h0002, 48'h0A0B0C0D0E0F, TGT,          MY_IP,        1'b0, 27, 1'b0};
    vecs[5] = '{16'h0002, 48'h0A0B0C0D0E0F, TGT,          32'hC0A80009, 1'b0, 28, 1'b0};
    vecs[6] = '{16'h0002, 48'h665544332211, TGT,          MY_IP,        1'b0, 46, 1'b1};

    // Reset state, during and after reset.
    tick();
    zero_check("in_reset");
    Rst = 1'b0;
    tick();
    zero_check("after_reset");

    // Table-driven request/reply rounds (MODE=1).
    for (int c = 0; c < 7; c++) begin
      do_reset();
      MODE = 1'b1;
      push_req(TGT);
      do_resolve(TGT);
      check($sformatf("c%0d_req", c), {Busy, TxReq, StateDbg}, {2'b11, ST_REQ});
      repeat (5) tick();
      grant_and_sof();
      capture_frame(1'b1, -1);
      TxGrant = 1'b0;
      check($sformatf("c%0d_wait", c), StateDbg, ST_WAIT);
      repeat (3) tick();
      send_reply(vecs[c], vecs[c].len, 1'b1);
      check($sformatf("c%0d_resolved", c), Resolved, vecs[c].exp_res);
      if (vecs[c].exp_res) begin
        check($sformatf("c%0d_mac", c), ResolvedMAC, vecs[c].smac);
        check($sformatf("c%0d_done", c), {Busy, Failed, TxReq, StateDbg}, {3'b000, ST_DONE});
      end else begin
        check($sformatf("c%0d_still_busy", c), {Busy, StateDbg}, {1'b1, ST_WAIT});
        n = 0;
        while (!TxReq && n < 200) begin tick(); n++; end
        check($sformatf("c%0d_retry", c), {TxReq, Resolved}, 2'b10);
      end
    end

    // No reply: three frames spaced by the timeout, then Failed.
    do_reset();
    MODE = 1'b1;
    do_resolve(32'hC0A800FE);
    for (int t = 0; t < 3; t++) begin
      if (t > 0) begin
        n = 0;
        while (!TxReq && n < 200) begin tick(); n++; end
        check($sformatf("retry%0d_txreq", t), TxReq, 1'b1);
        check($sformatf("retry%0d_gap_ge100", t), (n >= 100 && n <= 105), 1'b1);
      end
      push_req(32'hC0A800FE);
      grant_and_sof();
      capture_frame(1'b1, (t == 1) ? 10 : -1);  // grant dropped mid-frame on try 2
      TxGrant = 1'b0;
    end
    n = 0;
    while (!Failed && n < 200) begin tick(); n++; end
    check("fail_state", {Failed, Busy, TxReq, Resolved, StateDbg}, {4'b1000, ST_FAIL});
    check("fail_gap_ge100", (n >= 100 && n <= 105), 1'b1);
    cnt = 0;
    repeat (150) begin tick(); if (TxReq || ValOut) cnt++; end
    check("fail_quiet", cnt, 0);

    // MODE=0 pacing, Resolve while busy ignored, interrupted rx frame.
    do_reset();
    MODE = 1'b0;
    push_req(TGT);
    do_resolve(TGT);
    repeat (2) tick();
    grant_and_sof();
    capture_frame(1'b0, -1);
    TxGrant = 1'b0;
    check("m0_wait", StateDbg, ST_WAIT);
    do_resolve(32'hC0A80099);
    check("busy_resolve_ignored", {Busy, TxReq, StateDbg}, {2'b10, ST_WAIT});
    good2 = '{16'h0002, 48'h112233445566, TGT, MY_IP, 1'b0, 28, 1'b1};
    send_reply(good2, 16, 1'b0);
    check("partial_no_resolve", Resolved, 1'b0);
    send_reply(good2, 28, 1'b1);
    check("m0_resolved", {Resolved, Busy, StateDbg}, {2'b10, ST_DONE});
    check("m0_mac", ResolvedMAC, 48'h112233445566);
    cnt = 0;
    repeat (120) begin tick(); if (TxReq || ValOut) cnt++; end
    check("m0_single_frame", cnt, 0);
    do_resolve(TGT);
    check("reresolve_clears", {Resolved, Failed, Busy, TxReq}, 4'b0011);

    // Reset in the middle of a frame.
    MODE = 1'b1;
    grant_and_sof();
    repeat (6) tick();
    check("pre_rst_byte6", {FrameOut, ValOut, DataOut}, {2'b11, 8'h02});
    #2 Rst = 1'b1;
    #1 zero_check("rst_mid_send");
    tick(); tick();
    Rst = 1'b0;
    cnt = 0;
    repeat (80) begin tick(); if (TxReq || ValOut || FrameOut) cnt++; end
    check("no_resume_after_rst", {cnt[7:0], StateDbg}, {8'd0, ST_IDLE});
    TxGrant = 1'b0;

    // Reply arriving while the request is still being sent.
    do_reset();
    MODE = 1'b1;
    push_req(TGT);
    do_resolve(TGT);
    grant_and_sof();
    fork
      capture_frame(1'b1, -1);
      begin
        repeat (5) tick();
        send_reply(vecs[0], 28, 1'b1);
        check("mid_send_resolved", {Resolved, Busy, StateDbg}, {2'b11, ST_SEND});
      end
    join
    TxGrant = 1'b0;
    check("mid_send_done", {Resolved, Busy, TxReq, StateDbg}, {3'b100, ST_DONE});
    check("mid_send_mac", ResolvedMAC, 48'h0A0B0C0D0E0F);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/arp_resolver.md
Name: arp_resolver

Overview:
ARP initiator that is the counterpart of the ARP responder in the L2 stack.
- On command, it builds and transmits a broadcast ARP request for a target IP.
- It parses received ARP frames for the matching reply and delivers the resolved remote MAC to the UDP/IP transmit path.
- It retries on timeout and reports failure after a bounded number of attempts.

Parameters:
TIMEOUT_CYC, 25000000, clock cycles to wait for a reply after each request frame's last byte (24-bit counter minimum)
MAX_TRY, 3, total request transmissions before reporting failure (1..15)

Ports:
Clk  in  1  system clock, all logic on rising edge
Rst  in  1  asynchronous active-high reset
Resolve  in  1  single-cycle start pulse, TargetIP sampled same cycle
TargetIP  in  32  IP address to resolve
InnerMAC  in  48  local MAC
InnerIP  in  32  local IP
SoFIn  in  1  rx first ARP byte (hardware type MSB)
EoFIn  in  1  rx last byte
ValIn  in  1  rx byte valid
ErrIn  in  1  rx frame error, qualified with EoFIn
DataIn  in  8  rx ARP payload byte (after ethertype)
TxGrant  in  1  tx arbiter grant, level
MODE  in  1  0: one tx byte every second clock; 1: every clock
TxReq  out  1  request tx path
FrameOut  out  1  high for whole tx frame
ValOut  out  1  tx byte valid
SoFOut  out  1  first tx byte
EoFOut  out  1  last tx byte
DataOut  out  8  tx byte
Busy  out  1  resolution in progress
Resolved  out  1  level, ResolvedMAC valid
Failed  out  1  level, MAX_TRY exhausted
ResolvedMAC  out  48  learned sender MAC

Behaviour:
- Reset: all outputs 0, FSM IDLE, try counter 0, ResolvedMAC 0.
- FSM states: IDLE, REQ, SEND, WAIT, DONE, FAIL.
- IDLE/DONE/FAIL + Resolve:
  - latch TargetIP;
  - clear Resolved, Failed and the try counter;
  - go to REQ.
- Resolve while Busy (REQ/SEND/WAIT) is ignored.
- Busy = FSM in REQ, SEND or WAIT.
- REQ: TxReq=1.
  - A rising edge of TxGrant (previous-cycle sample 0, current 1) moves to SEND.
  - In SEND, the first byte appears with SoFOut=ValOut=FrameOut=1 exactly 2 clocks after the edge is sampled.
- SEND emits 60 bytes (index 0..59); no preamble, no FCS:
  - 0-5: FF.
  - 6-11: InnerMAC, MSB first.
  - 12-13: 08 06.
  - 14-21: 00 01 08 00 06 04 00 01.
  - 22-27: InnerMAC.
  - 28-31: InnerIP, MSB first.
  - 32-37: 00.
  - 38-41: TargetIP.
  - 42-59: 00.
- MODE=1: ValOut high every cycle for 60 cycles.
- MODE=0: ValOut high on alternate cycles, starting with the first byte; DataOut is held over the gap cycle.
- SoFOut and EoFOut pulse only with ValOut, on bytes 0 and 59.
- FrameOut is high from byte 0 through byte 59 inclusive, gaps included.
- The cycle after the EoFOut byte: FrameOut=0, TxReq=0, try counter +1, timeout counter loaded with TIMEOUT_CYC, go to WAIT.
- A grant dropping mid-frame is ignored; the frame always completes.
- WAIT: timeout counter decrements every clock. At 0:
  - try counter < MAX_TRY → REQ;
  - otherwise → FAIL, Failed=1.
- Rx parser runs in every state.
  - Byte index resets on SoFIn&&ValIn; it increments only on ValIn and saturates at 255.
  - Frame matches when all of these hold:
    - bytes 0-7 = 00 01 08 00 06 04 00 02;
    - sender IP (14-17) = latched TargetIP;
    - target IP (24-27) = InnerIP;
    - EoFIn&&ValIn with ErrIn=0, at index ≥ 27.
  - Sender MAC (8-13) is captured into a shadow register.
- A match is acted on only while Busy:
  - The shadow register is copied to ResolvedMAC and Resolved=1, one cycle after the EoF byte.
  - From REQ: drop TxReq → DONE.
  - From WAIT: → DONE.
  - From SEND: mark the match, finish the frame, then → DONE instead of WAIT; Resolved rises at match time.
- Match and timeout expiry in the same cycle: the match wins.
- ErrIn on EoF, a short frame, or a new SoF before EoF: discard, no state change.
- Resolved and Failed hold until the next accepted Resolve or Rst.
- Rst mid-frame: outputs drop to 0 asynchronously; no partial frame resumes.

Test Plan:
1. MODE=1, InnerMAC=02:00:00:00:00:01, InnerIP=C0A80001, Resolve TargetIP=C0A80002, grant after 5 cycles → TxReq high, then 60 consecutive ValOut bytes matching the layout starting FF×6, 02 00 00 00 00 01, 08 06; SoF/EoF on bytes 0/59; WAIT entered.
2. Reply with opcode 0002, sender 0A:0B:0C:0D:0E:0F / C0A80002, target IP C0A80001 → ResolvedMAC=0A0B0C0D0E0F, Resolved=1, Busy=0.
3. No reply, TIMEOUT_CYC=100, MAX_TRY=3 → exactly 3 frames, gaps ≥100 cycles, then Failed=1, TxReq stays 0.
4. Replies that must be rejected: with ErrIn on EoF, wrong sender IP, or opcode 0001 → Resolved stays 0 and retry proceeds.
5. MODE=0 → ValOut every other clock, 119 cycles from SoF to EoF, FrameOut continuous.
6. Rst asserted mid-SEND → all outputs 0 immediately. Resolve pulsed while Busy → ignored (single frame only).
